// File: rtl/sd_crc_7.sv
// sd_crc_7: serial CRC-7 (x^7 + x^3 + 1) generator/checker for SD command and response tokens
module sd_crc_7 (
  input  logic       BITVAL,
  input  logic       ENABLE,
  input  logic       BITSTRB,
  input  logic       CLEAR_N,
  output logic [6:0] CRC
);
  logic fb;
  assign fb = BITVAL ^ CRC[6];
  // Shift one message bit into the remainder per enabled bit clock; clear overrides everything
  always_ff @(posedge BITSTRB or negedge CLEAR_N)
    if (!CLEAR_N) CRC <= '0;
    else if (ENABLE) CRC <= {CRC[5:3], CRC[2] ^ fb, CRC[1:0], fb};
endmodule

// File: tb/tb_sd_crc_7.sv
// tb_sd_crc_7: randomized self-checking bench for sd_crc_7 against a polynomial long-division model
module tb_sd_crc_7;
  logic       BITVAL = 1'b0;
  logic       ENABLE = 1'b0;
  logic       BITSTRB = 1'b0;
  logic       CLEAR_N = 1'b0;
  logic [6:0] CRC;
  int checks = 0;
  int failures = 0;

  sd_crc_7 dut (.BITVAL(BITVAL), .ENABLE(ENABLE), .BITSTRB(BITSTRB), .CLEAR_N(CLEAR_N), .CRC(CRC));

  always #5 BITSTRB = ~BITSTRB;

  // Remainder of M(x) * x^7 divided by x^7 + x^3 + 1, message MSB first
  function automatic logic [6:0] crc_ref(input logic [63:0] v, input int n);
    logic a[$];
    logic [7:0] g;
    logic [6:0] r;
    g = 8'b1000_1001;
    for (int i = n - 1; i >= 0; i--) a.push_back(v[i]);
    for (int i = 0; i < 7; i++) a.push_back(1'b0);
    for (int i = 0; i < n; i++)
      if (a[i]) for (int j = 0; j < 8; j++) a[i + j] = a[i + j] ^ g[7 - j];
    for (int k = 0; k < 7; k++) r[6 - k] = a[n + k];
    return r;
  endfunction

  task automatic clear();
    @(negedge BITSTRB);
    ENABLE = 1'b0;
    CLEAR_N = 1'b0;
    #1;
    CLEAR_N = 1'b1;
  endtask

  task automatic send(input logic [63:0] v, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps)
        repeat ($urandom_range(0, 3)) begin
          @(negedge BITSTRB);
          ENABLE = 1'b0;
          BITVAL = 1'($urandom);
        end
      @(negedge BITSTRB);
      BITVAL = v[i];
      ENABLE = 1'b1;
    end
    @(negedge BITSTRB);
    ENABLE = 1'b0;
    BITVAL = 1'($urandom);
  endtask

  task automatic test_reset();
    clear();
    checks++;
    if (CRC !== 7'h00) begin failures++; $display("FAIL reset_init crc=%h exp=00", CRC); end
    send(64'h1, 1, 0);
    #2;
    CLEAR_N = 1'b0;
    #1;
    checks++;
    if (CRC !== 7'h00) begin failures++; $display("FAIL reset_async crc=%h exp=00", CRC); end
    ENABLE = 1'b1;
    BITVAL = 1'b1;
    repeat (3) begin
      @(negedge BITSTRB);
      checks++;
      if (CRC !== 7'h00) begin failures++; $display("FAIL reset_hold crc=%h exp=00", CRC); end
    end
    ENABLE = 1'b0;
    CLEAR_N = 1'b1;
  endtask

  task automatic test_single_bit();
    clear();
    send(64'h1, 1, 0);
    checks++;
    if (CRC !== 7'h09) begin failures++; $display("FAIL single_one crc=%h exp=09", CRC); end
    clear();
    send(64'h0, 1, 0);
    checks++;
    if (CRC !== 7'h00) begin failures++; $display("FAIL single_zero crc=%h exp=00", CRC); end
  endtask

  task automatic test_hold();
    logic [63:0] v;
    logic [6:0] exp;
    v = {$urandom, $urandom};
    exp = crc_ref(v, 24);
    clear();
    send(v, 24, 0);
    repeat (10) begin
      @(negedge BITSTRB);
      BITVAL = 1'($urandom);
      checks++;
      if (CRC !== exp) begin failures++; $display("FAIL hold crc=%h exp=%h", CRC, exp); end
    end
  endtask

  task automatic test_known_cmds();
    logic [39:0] cmd [4];
    logic [6:0] exp [4];
    cmd = '{40'h40_0000_0000, 40'h51_0000_0000, 40'h48_0000_01AA, 40'h77_0000_0000};
    exp = '{7'h4A, 7'h2A, 7'h43, 7'h32};
    for (int i = 0; i < 4; i++) begin
      clear();
      send({24'h0, cmd[i]}, 40, 0);
      checks++;
      if (CRC !== exp[i]) begin failures++; $display("FAIL cmd%0d crc=%h exp=%h", i, CRC, exp[i]); end
    end
  endtask

  task automatic test_gapped();
    clear();
    send({24'h0, 40'h40_0000_0000}, 40, 1);
    checks++;
    if (CRC !== 7'h4A) begin failures++; $display("FAIL gapped_cmd0 crc=%h exp=4a", CRC); end
  endtask

  task automatic test_reset_mid();
    clear();
    send({24'h0, 40'h48_0000_01AA} >> 20, 20, 0);
    clear();
    checks++;
    if (CRC !== 7'h00) begin failures++; $display("FAIL mid_clear crc=%h exp=00", CRC); end
    send({24'h0, 40'h48_0000_01AA}, 40, 0);
    checks++;
    if (CRC !== 7'h43) begin failures++; $display("FAIL mid_cmd8 crc=%h exp=43", CRC); end
  endtask

  task automatic test_random();
    logic [63:0] v;
    int n;
    logic [6:0] exp;
    for (int t = 0; t < 20; t++) begin
      v = {$urandom, $urandom};
      n = $urandom_range(1, 64);
      exp = crc_ref(v, n);
      clear();
      send(v, n, t[0]);
      checks++;
      if (CRC !== exp) begin failures++; $display("FAIL random%0d n=%0d crc=%h exp=%h", t, n, CRC, exp); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_bit();
    test_hold();
    test_known_cmds();
    test_gapped();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
